// File: rtl/pll_lock_controller.sv
// pll_lock_controller: PFD reset sequencing, charge-pump gating and UP/DOWN pulse-width lock detection.
// Latency: every output is a register updated on the state-transition edge; no backpressure (free-running inputs).
// Define PLL_LOCK_RETRY_COUNTER_EN to build the saturating acquisition retry counter; otherwise it reads 0.
module pll_lock_controller #(
    parameter int WIDTH_W      = 8,
    parameter int LOCK_TOL     = 2,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int ACQ_TIMEOUT  = 1024,
    parameter int RESET_HOLD   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       input_enable_digital,
    input  logic       input_reference_clock_digital,
    input  logic       input_up_digital,
    input  logic       input_down_digital,
    output logic       output_pfd_reset_digital,
    output logic       output_charge_pump_enable_digital,
    output logic       output_locked_digital,
    output logic       output_timeout_digital,
    output logic [1:0] output_state_digital,
    output logic [7:0] output_retry_count_digital
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int GS_W = $clog2(LOCK_COUNT + 1);
    localparam int BS_W = $clog2(UNLOCK_COUNT + 1);
    localparam int AP_W = $clog2(ACQ_TIMEOUT + 1);
    localparam int HC_W = $clog2(RESET_HOLD + 1);

    localparam logic [WIDTH_W-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH_W:0]   TOL        = (WIDTH_W+1)'(LOCK_TOL);
    localparam logic [GS_W-1:0]    GS_LOCK    = GS_W'(LOCK_COUNT);
    localparam logic [BS_W-1:0]    BS_UNLOCK  = BS_W'(UNLOCK_COUNT);
    localparam logic [AP_W-1:0]    AP_TIMEOUT = AP_W'(ACQ_TIMEOUT);
    localparam logic [HC_W-1:0]    HC_LAST    = HC_W'(RESET_HOLD - 1);

    state_t              state_q, state_d;
    logic                ref_prev_q, ref_prev_d;
    logic [WIDTH_W-1:0]  up_cnt_q, up_cnt_d;
    logic [WIDTH_W-1:0]  down_cnt_q, down_cnt_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [GS_W-1:0]     good_streak_q, good_streak_d;
    logic [BS_W-1:0]     bad_streak_q, bad_streak_d;
    logic [AP_W-1:0]     acq_periods_q, acq_periods_d;
    logic                discard_q, discard_d;
    logic                timeout_evt;

    logic                pfd_reset_q, pfd_reset_d;
    logic                cp_en_q, cp_en_d;
    logic                locked_q, locked_d;
    logic                timeout_q, timeout_d;

    logic                ref_rise;
    logic [WIDTH_W:0]    up_ext, down_ext, width_diff;
    logic                win_good;
    logic [GS_W-1:0]     gs_next;
    logic [BS_W-1:0]     bs_next;
    logic [AP_W-1:0]     ap_next;

    assign ref_rise = ~ref_prev_q & input_reference_clock_digital;

    // Window quality: unsigned absolute difference one bit wider than the counters, so it never wraps.
    assign up_ext     = {1'b0, up_cnt_q};
    assign down_ext   = {1'b0, down_cnt_q};
    assign width_diff = (up_ext >= down_ext) ? (up_ext - down_ext) : (down_ext - up_ext);
    assign win_good   = (width_diff <= TOL) && (up_cnt_q != CNT_MAX) && (down_cnt_q != CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ref_prev_q    <= 1'b0;
            up_cnt_q      <= '0;
            down_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            good_streak_q <= '0;
            bad_streak_q  <= '0;
            acq_periods_q <= '0;
            discard_q     <= 1'b0;
            pfd_reset_q   <= 1'b1;
            cp_en_q       <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_prev_q    <= ref_prev_d;
            up_cnt_q      <= up_cnt_d;
            down_cnt_q    <= down_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            good_streak_q <= good_streak_d;
            bad_streak_q  <= bad_streak_d;
            acq_periods_q <= acq_periods_d;
            discard_q     <= discard_d;
            pfd_reset_q   <= pfd_reset_d;
            cp_en_q       <= cp_en_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = '0;
        good_streak_d = good_streak_q;
        bad_streak_d  = bad_streak_q;
        acq_periods_d = acq_periods_q;
        discard_d     = discard_q;
        timeout_evt   = 1'b0;
        gs_next       = win_good ? (good_streak_q + GS_W'(1)) : '0;
        bs_next       = win_good ? '0 : (bad_streak_q + BS_W'(1));
        ap_next       = acq_periods_q + AP_W'(1);

        case (state_q)
            IDLE: begin
                good_streak_d = '0;
                bad_streak_d  = '0;
                acq_periods_d = '0;
                discard_d     = 1'b0;
                if (input_enable_digital) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                good_streak_d = '0;
                bad_streak_d  = '0;
                acq_periods_d = '0;
                hold_cnt_d    = hold_cnt_q + HC_W'(1);
                if (hold_cnt_q == HC_LAST) begin
                    state_d    = ACQUIRE;
                    hold_cnt_d = '0;
                    discard_d  = 1'b1;
                end
            end
            ACQUIRE: begin
                if (ref_rise && discard_q) begin
                    discard_d = 1'b0;
                end else if (ref_rise) begin
                    good_streak_d = gs_next;
                    acq_periods_d = ap_next;
                    // Lock is tested first so it wins over a timeout on the same evaluation.
                    if (win_good && (gs_next == GS_LOCK)) begin
                        state_d      = LOCKED;
                        bad_streak_d = '0;
                    end else if (ap_next == AP_TIMEOUT) begin
                        state_d       = HOLD;
                        timeout_evt   = 1'b1;
                        good_streak_d = '0;
                        acq_periods_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (ref_rise) begin
                    bad_streak_d = bs_next;
                    if (!win_good && (bs_next == BS_UNLOCK)) begin
                        state_d       = ACQUIRE;
                        good_streak_d = '0;
                        acq_periods_d = '0;
                        bad_streak_d  = '0;
                        discard_d     = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!input_enable_digital) begin
            state_d       = IDLE;
            timeout_evt   = 1'b0;
            hold_cnt_d    = '0;
            good_streak_d = '0;
            bad_streak_d  = '0;
            acq_periods_d = '0;
            discard_d     = 1'b0;
        end

        ref_prev_d = (state_d == IDLE) ? 1'b0 : input_reference_clock_digital;

        // Measurement counters restart from the current cycle's UP/DOWN at each reference edge.
        up_cnt_d   = up_cnt_q;
        down_cnt_d = down_cnt_q;
        if ((state_q == ACQUIRE) || (state_q == LOCKED)) begin
            if (ref_rise) begin
                up_cnt_d   = {{(WIDTH_W-1){1'b0}}, input_up_digital};
                down_cnt_d = {{(WIDTH_W-1){1'b0}}, input_down_digital};
            end else begin
                if (input_up_digital && (up_cnt_q != CNT_MAX)) begin
                    up_cnt_d = up_cnt_q + WIDTH_W'(1);
                end
                if (input_down_digital && (down_cnt_q != CNT_MAX)) begin
                    down_cnt_d = down_cnt_q + WIDTH_W'(1);
                end
            end
        end
        if ((state_d == IDLE) || (state_d == HOLD)) begin
            up_cnt_d   = '0;
            down_cnt_d = '0;
        end
    end

    always_comb begin
        pfd_reset_d = (state_d == IDLE) || (state_d == HOLD);
        cp_en_d     = (state_d == ACQUIRE) || (state_d == LOCKED);
        locked_d    = (state_d == LOCKED);
        timeout_d   = timeout_evt;
    end

    assign output_pfd_reset_digital          = pfd_reset_q;
    assign output_charge_pump_enable_digital = cp_en_q;
    assign output_locked_digital             = locked_q;
    assign output_timeout_digital            = timeout_q;
    assign output_state_digital              = state_q;

`ifdef PLL_LOCK_RETRY_COUNTER_EN
    logic [7:0] retry_cnt_q, retry_cnt_d;

    // Survives IDLE on purpose: only reset_n clears the retry history.
    always_comb begin
        retry_cnt_d = retry_cnt_q;
        if (timeout_evt && (retry_cnt_q != 8'hFF)) begin
            retry_cnt_d = retry_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt_q <= 8'd0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign output_retry_count_digital = retry_cnt_q;
`else
    assign output_retry_count_digital = 8'd0;
`endif

endmodule
